// File: rtl/daw_pkg.sv
// daw_pkg: shared types for the capture-to-SD packing path.
package daw_pkg;

    localparam int WORD_WIDTH = 8;

    typedef logic [WORD_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_WAIT,
        W_PAD
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_STREAM
    } rd_state_e;

    localparam sample_t PAD_BYTE = 8'h00;

endpackage

// File: rtl/packer_ram.sv
// packer_ram: simple dual-port block store, one write and one registered read.
// The buffer index is the address MSB; the read word only changes when rd_en is set.
module packer_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_in,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_block_packer.sv
// sample_block_packer: packs sample strobes into ping-pong SD blocks and streams them out.
// Optional PACKER_STATS_EN adds blocks_out / drops_out counters.
module sample_block_packer #(
    parameter int WORD_WIDTH  = 8,
    parameter int BLOCK_BYTES = 512,
    parameter int NUM_BUFS    = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  record_in,
    input  logic                  sample_valid_in,
    input  logic [WORD_WIDTH-1:0] sample_in,
    output logic                  blk_valid_out,
    output logic [WORD_WIDTH-1:0] blk_data_out,
    output logic                  blk_first_out,
    output logic                  blk_last_out,
    input  logic                  blk_ready_in,
    output logic                  busy_out,
`ifdef PACKER_STATS_EN
    output logic [15:0]           blocks_out,
    output logic [15:0]           drops_out,
`endif
    output logic                  overrun_out
);

    import daw_pkg::*;

    localparam int IW    = $clog2(BLOCK_BYTES);
    localparam int AW    = IW + 1;
    localparam int DEPTH = NUM_BUFS * BLOCK_BYTES;

    localparam logic [IW-1:0] IDX_LAST = IW'(BLOCK_BYTES - 1);
    localparam logic [IW-1:0] IDX_PEN  = IW'(BLOCK_BYTES - 2);

    wr_state_e wr_st;
    rd_state_e rd_st;

    logic                  rec_q;
    logic                  rise;
    logic                  fall;
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         wr_idx_nx;
    logic [IW-1:0]         fill_nx;
    logic                  wr_buf;
    logic                  wr_en;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  mark_full;
    logic [1:0]            buf_full;
    logic [1:0]            set_v;
    logic [1:0]            clr_v;
    logic                  rd_buf;
    logic [IW-1:0]         rd_idx;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [WORD_WIDTH-1:0] ram_q;
    logic                  rd_acc;
    logic                  rd_done;

    assign rise      = record_in & ~rec_q;
    assign fall      = ~record_in & rec_q;
    assign wr_en     = (wr_st == W_FILL && sample_valid_in) || wr_st == W_PAD;
    assign wr_data   = (wr_st == W_PAD) ? WORD_WIDTH'(PAD_BYTE) : sample_in;
    assign mark_full = wr_en && wr_idx == IDX_LAST;
    assign wr_idx_nx = wr_idx + IW'(1);
    assign fill_nx   = sample_valid_in ? wr_idx_nx : wr_idx;

    assign rd_acc  = rd_st == R_STREAM && blk_valid_out && blk_ready_in;
    assign rd_done = rd_acc && rd_idx == IDX_LAST;

    assign set_v = mark_full ? (wr_buf ? 2'b10 : 2'b01) : 2'b00;
    assign clr_v = rd_done ? (rd_buf ? 2'b10 : 2'b01) : 2'b00;

    assign busy_out = !(wr_st == W_IDLE && rd_st == R_IDLE && buf_full == 2'b00);

    packer_ram #(
        .W     (WORD_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_in  (clk_in),
        .wr_en   (wr_en),
        .wr_addr ({wr_buf, wr_idx}),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Buffers are filled and drained strictly alternately, so wr_buf/rd_buf
    // double as "next in order" pointers and no age tracking is needed.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            buf_full <= 2'b00;
        end else begin
            buf_full <= (buf_full | set_v) & ~clr_v;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_st       <= W_IDLE;
            wr_idx      <= '0;
            wr_buf      <= 1'b0;
            overrun_out <= 1'b0;
            rec_q       <= 1'b0;
        end else begin
            rec_q <= record_in;
            unique case (wr_st)
                W_IDLE: begin
                    if (rise) begin
                        overrun_out <= 1'b0;
                        wr_idx      <= '0;
                        wr_st       <= buf_full[wr_buf] ? W_WAIT : W_FILL;
                    end
                end
                W_FILL: begin
                    if (sample_valid_in) begin
                        wr_idx <= wr_idx_nx;
                        if (mark_full) begin
                            wr_buf <= ~wr_buf;
                        end
                    end
                    if (fall) begin
                        wr_st <= (fill_nx == '0) ? W_IDLE : W_PAD;
                    end else if (mark_full && buf_full[~wr_buf]) begin
                        wr_st <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (sample_valid_in) begin
                        overrun_out <= 1'b1;
                    end
                    if (fall) begin
                        wr_st <= W_IDLE;
                    end else if (!buf_full[wr_buf]) begin
                        wr_st <= W_FILL;
                    end
                end
                W_PAD: begin
                    wr_idx <= wr_idx_nx;
                    if (mark_full) begin
                        wr_buf <= ~wr_buf;
                        wr_st  <= W_IDLE;
                    end
                end
                default: wr_st <= W_IDLE;
            endcase
        end
    end

    // ram_q always holds the byte after the one on blk_data_out while streaming.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = {rd_buf, IW'(0)};
        unique case (rd_st)
            R_IDLE: begin
                rd_en = buf_full[rd_buf];
            end
            R_FETCH: begin
                rd_en   = 1'b1;
                rd_addr = {rd_buf, IW'(1)};
            end
            R_STREAM: begin
                rd_en = rd_acc;
                if (rd_done) begin
                    rd_addr = {~rd_buf, IW'(0)};
                end else begin
                    rd_addr = {rd_buf, rd_idx + IW'(2)};
                end
            end
            default: rd_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rd_st         <= R_IDLE;
            rd_buf        <= 1'b0;
            rd_idx        <= '0;
            blk_valid_out <= 1'b0;
            blk_data_out  <= '0;
            blk_first_out <= 1'b0;
            blk_last_out  <= 1'b0;
        end else begin
            unique case (rd_st)
                R_IDLE: begin
                    if (buf_full[rd_buf]) begin
                        rd_st <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    blk_data_out  <= ram_q;
                    blk_valid_out <= 1'b1;
                    blk_first_out <= 1'b1;
                    blk_last_out  <= 1'b0;
                    rd_idx        <= '0;
                    rd_st         <= R_STREAM;
                end
                R_STREAM: begin
                    if (rd_done) begin
                        blk_valid_out <= 1'b0;
                        blk_first_out <= 1'b0;
                        blk_last_out  <= 1'b0;
                        rd_buf        <= ~rd_buf;
                        rd_st         <= buf_full[~rd_buf] ? R_FETCH : R_IDLE;
                    end else if (rd_acc) begin
                        blk_data_out  <= ram_q;
                        blk_first_out <= 1'b0;
                        blk_last_out  <= rd_idx == IDX_PEN;
                        rd_idx        <= rd_idx + IW'(1);
                    end
                end
                default: rd_st <= R_IDLE;
            endcase
        end
    end

`ifdef PACKER_STATS_EN
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            blocks_out <= '0;
            drops_out  <= '0;
        end else begin
            if (rise) begin
                blocks_out <= '0;
            end else if (rd_done) begin
                blocks_out <= blocks_out + 16'd1;
            end
            if (wr_st == W_WAIT && sample_valid_in && drops_out != 16'hFFFF) begin
                drops_out <= drops_out + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sample_block_packer.sv
// tb_sample_block_packer: directed scenarios plus random traffic against a
// queue-based model of the block stream.
module tb_sample_block_packer;

    localparam int BB = 8;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       record_in;
    logic       sample_valid_in;
    logic [7:0] sample_in;
    logic       blk_valid_out;
    logic [7:0] blk_data_out;
    logic       blk_first_out;
    logic       blk_last_out;
    logic       blk_ready_in;
    logic       busy_out;
    logic       overrun_out;
`ifdef PACKER_STATS_EN
    logic [15:0] blocks_out;
    logic [15:0] drops_out;
`endif

    always #5 clk_in = ~clk_in;

    sample_block_packer #(
        .WORD_WIDTH  (8),
        .BLOCK_BYTES (BB),
        .NUM_BUFS    (2)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .record_in       (record_in),
        .sample_valid_in (sample_valid_in),
        .sample_in       (sample_in),
        .blk_valid_out   (blk_valid_out),
        .blk_data_out    (blk_data_out),
        .blk_first_out   (blk_first_out),
        .blk_last_out    (blk_last_out),
        .blk_ready_in    (blk_ready_in),
        .busy_out        (busy_out),
`ifdef PACKER_STATS_EN
        .blocks_out      (blocks_out),
        .drops_out       (drops_out),
`endif
        .overrun_out     (overrun_out)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 filling, 2 waiting for a buffer, 3 padding.
    int         cyc = 0;
    bit         armed = 1'b0;
    bit         m_rec_q;
    int         m_mode;
    logic [7:0] m_cur[$];
    logic [7:0] m_bytes[$];
    int         m_fe[$];
    int         m_pos;
    int         m_last_end;
    bit         m_ovr;
    int         m_blocks;
    int         m_drops;
    bit         mv, mrise, mfall, mdone;
    int         mnf;
    logic [7:0] acc_q[$];
    logic [7:0] e2[8];
    logic [7:0] e4[16];

    // A completed block appears 2 cycles after it is complete, or 1 cycle
    // after the previous block ends when it was already waiting.
    function automatic bit exp_valid();
        int s;
        if (m_fe.size() == 0) return 1'b0;
        s = m_fe[0] + 2;
        if (m_last_end + 1 > s) s = m_last_end + 1;
        return cyc >= s;
    endfunction

    task automatic complete_blk();
        foreach (m_cur[i]) m_bytes.push_back(m_cur[i]);
        m_fe.push_back(cyc);
        m_cur.delete();
    endtask

    initial begin
        forever begin
            @(posedge clk_in);
            if (!rst_in) begin
                cyc        = cyc + 1;
                armed      = 1'b1;
                m_rec_q    = 1'b0;
                m_mode     = 0;
                m_cur.delete();
                m_bytes.delete();
                m_fe.delete();
                m_pos      = 0;
                m_last_end = -100;
                m_ovr      = 1'b0;
                m_blocks   = 0;
                m_drops    = 0;
            end else begin
                mv    = exp_valid();
                mnf   = m_fe.size();
                mrise = record_in && !m_rec_q;
                mfall = !record_in && m_rec_q;
                cyc   = cyc + 1;
                if (mv && blk_ready_in) begin
                    m_pos++;
                    if (m_pos == BB) begin
                        repeat (BB) m_bytes.delete(0);
                        m_fe.delete(0);
                        m_pos      = 0;
                        m_last_end = cyc;
                        m_blocks   = (m_blocks + 1) & 16'hFFFF;
                    end
                end
                mdone = 1'b0;
                case (m_mode)
                    0: if (mrise) begin
                        m_ovr = 1'b0;
                        m_cur.delete();
                        m_mode = (mnf < 2) ? 1 : 2;
                    end
                    1: begin
                        if (sample_valid_in) begin
                            m_cur.push_back(sample_in);
                            if (m_cur.size() == BB) begin
                                complete_blk();
                                mdone = 1'b1;
                            end
                        end
                        if (mfall) m_mode = (m_cur.size() == 0) ? 0 : 3;
                        else if (mdone && mnf >= 1) m_mode = 2;
                    end
                    2: begin
                        if (sample_valid_in) begin
                            m_ovr = 1'b1;
                            if (m_drops < 65535) m_drops++;
                        end
                        if (mfall) m_mode = 0;
                        else if (mnf < 2) m_mode = 1;
                    end
                    default: begin
                        m_cur.push_back(8'h00);
                        if (m_cur.size() == BB) begin
                            complete_blk();
                            m_mode = 0;
                        end
                    end
                endcase
                if (mrise) m_blocks = 0;
                m_rec_q = record_in;
            end
        end
    end

    initial begin
        bit ev;
        forever begin
            @(negedge clk_in);
            if (armed) begin
                ev = exp_valid();
                chk("valid", blk_valid_out, ev);
                if (ev && blk_valid_out) begin
                    chk("data", blk_data_out, m_bytes[m_pos]);
                    chk("first", blk_first_out, m_pos == 0);
                    chk("last", blk_last_out, m_pos == BB - 1);
                end
                chk("busy", busy_out, m_mode != 0 || m_fe.size() != 0);
                chk("overrun", overrun_out, m_ovr);
`ifdef PACKER_STATS_EN
                chk("blocks", blocks_out, m_blocks);
                chk("drops", drops_out, m_drops);
`endif
                if (blk_valid_out && blk_ready_in) acc_q.push_back(blk_data_out);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic strobe(logic [7:0] b);
        sample_in       = b;
        sample_valid_in = 1'b1;
        step();
        sample_valid_in = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_in = 1'b0;
        step();
        rst_in = 1'b1;
    endtask

    task automatic chk_acc(string nm, int base);
        for (int i = 0; i < acc_q.size(); i++) begin
            chk(nm, acc_q[i], 8'(base + i));
        end
    endtask

    initial begin
        int n;
        rst_in          = 1'b0;
        record_in       = 1'b0;
        sample_valid_in = 1'b0;
        sample_in       = 8'h00;
        blk_ready_in    = 1'b1;
        idle(2);
        chk("rst_valid", blk_valid_out, 0);
        chk("rst_data", blk_data_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_overrun", overrun_out, 0);
        rst_in = 1'b1;

        // 1: one full block at full rate
        acc_q.delete();
        record_in = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) strobe(8'(i));
        record_in = 1'b0;
        idle(12);
        chk("s1_count", acc_q.size(), 8);
        chk_acc("s1_bytes", 1);
        chk("s1_busy", busy_out, 0);

        // 2: partial block is zero padded
        acc_q.delete();
        e2 = '{8'hA0, 8'hA1, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        record_in = 1'b1;
        step();
        for (int i = 0; i < 3; i++) strobe(8'hA0 + 8'(i));
        record_in = 1'b0;
        idle(20);
        chk("s2_count", acc_q.size(), 8);
        foreach (acc_q[i]) if (i < 8) chk("s2_bytes", acc_q[i], e2[i]);

        // 3: consumer stalled, third block dropped
        pulse_reset();
        acc_q.delete();
        blk_ready_in = 1'b0;
        record_in    = 1'b1;
        step();
        for (int i = 0; i < 24; i++) strobe(8'h10 + 8'(i));
        chk("s3_overrun", overrun_out, 1);
        blk_ready_in = 1'b1;
        idle(30);
        chk("s3_count", acc_q.size(), 16);
        chk_acc("s3_bytes", 16);
`ifdef PACKER_STATS_EN
        chk("s6_blocks", blocks_out, 2);
        chk("s6_drops", drops_out, 8);
        record_in = 1'b0;
        step();
        record_in = 1'b1;
        step();
        chk("s6_clear", blocks_out, 0);
`endif
        record_in = 1'b0;
        idle(3);

        // 4: ready toggling every cycle
        acc_q.delete();
        record_in = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            e4[i]           = 8'($urandom);
            sample_in       = e4[i];
            sample_valid_in = 1'b1;
            blk_ready_in    = ~blk_ready_in;
            step();
        end
        sample_valid_in = 1'b0;
        record_in       = 1'b0;
        for (int i = 0; i < 40; i++) begin
            blk_ready_in = ~blk_ready_in;
            step();
        end
        blk_ready_in = 1'b1;
        idle(4);
        chk("s4_count", acc_q.size(), 16);
        foreach (acc_q[i]) if (i < 16) chk("s4_bytes", acc_q[i], e4[i]);

        // 5: reset while streaming abandons everything
        acc_q.delete();
        record_in = 1'b1;
        step();
        for (int i = 0; i < 8; i++) strobe(8'h40 + 8'(i));
        for (int i = 0; i < 5; i++) strobe(8'h50 + 8'(i));
        rst_in    = 1'b0;
        record_in = 1'b0;
        step();
        chk("s5_valid", blk_valid_out, 0);
        chk("s5_data", blk_data_out, 0);
        chk("s5_first", blk_first_out, 0);
        chk("s5_last", blk_last_out, 0);
        chk("s5_busy", busy_out, 0);
        rst_in = 1'b1;
        n = acc_q.size();
        idle(12);
        chk("s5_nomore", acc_q.size(), n);
        acc_q.delete();
        record_in = 1'b1;
        step();
        for (int i = 0; i < 8; i++) strobe(8'h60 + 8'(i));
        record_in = 1'b0;
        idle(12);
        chk("s5_count", acc_q.size(), 8);
        chk_acc("s5_bytes", 8'h60);

        // random traffic, varying consumer throughput
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 39) == 0) record_in = ~record_in;
                sample_valid_in = 1'($urandom_range(0, 1));
                sample_in       = 8'($urandom);
                blk_ready_in    = $urandom_range(0, 9) < 2 + seg;
                rst_in          = $urandom_range(0, 599) != 0;
                step();
            end
        end
        rst_in          = 1'b1;
        sample_valid_in = 1'b0;
        record_in       = 1'b0;
        blk_ready_in    = 1'b1;
        idle(60);
        chk("end_busy", busy_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
